// File: rtl/frame_pair_streamer.sv
// frame_pair_streamer: captures one frame at a time from a byte-serial load port into
// ping-pong banks. It then streams each new-frame pixel (curr) in lockstep with the
// co-located pixel of the previous frame (prev), using a joint val/rdy handshake.
module frame_pair_streamer #(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_wr_msg,
    input  logic        i_wr_val,
    output logic        o_wr_rdy,
    output logic [7:0]  o_send_curr_msg,
    output logic        o_send_curr_val,
    input  logic        i_send_curr_rdy,
    output logic [7:0]  o_send_prev_msg,
    output logic        o_send_prev_val,
    input  logic        i_send_prev_rdy,
    output logic        o_frame_done,
    output logic [15:0] o_frame_count
);

    localparam int unsigned N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_mem [2][N];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic                r_bank_sel;
    logic                r_have_prev;
    logic [15:0]         r_frame_count;
    logic                r_frame_done;

    logic                w_wr_fire;
    logic                w_last_wr;
    logic                w_xfer;
    logic                w_last_xfer;
    logic [IDX_W-1:0]    w_wr_idx;
    logic [IDX_W-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_fire   = 1'b0;
        w_last_wr   = 1'b0;
        w_xfer      = 1'b0;
        w_last_xfer = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_wr_fire = i_wr_val;
                w_last_wr = w_wr_fire && (r_wr_ptr == ADDR_W'(N - 1));
                if (w_last_wr) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // Both consumers must accept; neither stream advances alone
                w_xfer      = i_send_curr_rdy && i_send_prev_rdy;
                w_last_xfer = w_xfer && (r_rd_ptr == ADDR_W'(N - 1));
                if (w_last_xfer) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Pointers, bank selection, frame bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_bank_sel    <= 1'b0;
            r_have_prev   <= 1'b0;
            r_frame_count <= 16'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_last_xfer;
            if (w_wr_fire) begin
                r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + ADDR_W'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= w_last_xfer ? '0 : r_rd_ptr + ADDR_W'(1);
            end
            if (w_last_xfer) begin
                r_bank_sel    <= ~r_bank_sel;
                r_have_prev   <= 1'b1;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Frame banks; contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_wr_fire && !i_reset) begin
            r_mem[r_bank_sel][w_wr_idx] <= i_wr_msg;
        end
    end

    assign o_wr_rdy        = (r_state == S_LOAD);
    assign o_send_curr_val = (r_state == S_STREAM);
    assign o_send_prev_val = (r_state == S_STREAM);
    // Combinational read so data is valid in the first STREAM cycle
    assign o_send_curr_msg = r_mem[r_bank_sel][w_rd_idx];
    // First frame after reset is paired with a black frame
    assign o_send_prev_msg = r_have_prev ? r_mem[~r_bank_sel][w_rd_idx] : 8'd0;
    assign o_frame_done    = r_frame_done;
    assign o_frame_count   = r_frame_count;

endmodule
